// File: rtl/strided_vector_mem_ctr_if.sv
// strided_vector_mem_ctr_if: core request/response and data-cache bus of the strided vector memory controller (slave = controller, master = core plus cache)
interface strided_vector_mem_ctr_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN = 32,
  parameter int VECTOR_SIZE = 8,
  parameter int ENTRY_INDEX_SIZE = 3
);
  logic mem_access_enabled;
  logic [1:0] data_vis_signal;
  logic is_vector;
  logic [1:0] scalar_data_type;
  logic [2:0] vector_data_type;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [ADDR_WIDTH-1:0] stride;
  logic [ENTRY_INDEX_SIZE:0] length;
  logic [VECTOR_SIZE-1:0] mask;
  logic [LEN-1:0] written_scalar_data;
  logic [LEN*VECTOR_SIZE-1:0] written_vector_data;
  logic [LEN-1:0] scalar_data;
  logic [LEN*VECTOR_SIZE-1:0] vector_data;
  logic [1:0] mem_vis_status;
  logic [LEN-1:0] mem_data;
  logic [1:0] d_cache_status;
  logic [1:0] cache_vis_signal;
  logic [ADDR_WIDTH-1:0] mem_vis_addr;
  logic [2:0] data_type;
  logic [LEN-1:0] cache_written_data;
  logic [ENTRY_INDEX_SIZE:0] write_length;
  modport slave (
    input mem_access_enabled, data_vis_signal, is_vector, scalar_data_type, vector_data_type,
          data_addr, stride, length, mask, written_scalar_data, written_vector_data,
          mem_data, d_cache_status,
    output scalar_data, vector_data, mem_vis_status, cache_vis_signal, mem_vis_addr,
           data_type, cache_written_data, write_length
  );
  modport master (
    output mem_access_enabled, data_vis_signal, is_vector, scalar_data_type, vector_data_type,
           data_addr, stride, length, mask, written_scalar_data, written_vector_data,
           mem_data, d_cache_status,
    input scalar_data, vector_data, mem_vis_status, cache_vis_signal, mem_vis_addr,
          data_type, cache_written_data, write_length
  );
endinterface

// File: rtl/strided_vector_mem_ctr.sv
// strided_vector_mem_ctr: turns masked, signed-stride vector and scalar load/store requests on bus (slave) into single-element cache accesses; clk, async active-high rst
module strided_vector_mem_ctr #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN = 32,
  parameter int BYTE_SIZE = 8,
  parameter int VECTOR_SIZE = 8,
  parameter int ENTRY_INDEX_SIZE = 3
) (
  input logic clk,
  input logic rst,
  strided_vector_mem_ctr_if.slave bus
);
  localparam int VW = LEN * VECTOR_SIZE;
  localparam int IW = ENTRY_INDEX_SIZE + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic [1:0] op_r;
  logic vec_r;
  logic [1:0] code_r;
  logic [ADDR_WIDTH-1:0] base_r, stride_r;
  logic [IW-1:0] len_r, idx, fidx;
  logic [VECTOR_SIZE-1:0] mask_r;
  logic [VW-1:0] wvec_r, vbuf;
  logic [LEN-1:0] sbuf, emask;
  logic [15:0] sh_issue, sh_load;
  logic found, issue, go, accept, resting, fin;
  assign go = bus.data_vis_signal == 2'd1 || bus.data_vis_signal == 2'd2;
  assign accept = state == IDLE && bus.mem_access_enabled && go;
  assign resting = bus.d_cache_status == 2'd0;
  assign fin = bus.d_cache_status == 2'd2;
  assign issue = state == ISSUE && found && resting;
  assign emask = code_r[1] ? '1 : code_r[0] ? LEN'({(2*BYTE_SIZE){1'b1}}) : LEN'({BYTE_SIZE{1'b1}});
  assign sh_issue = 16'(fidx) * (16'(BYTE_SIZE) << code_r);
  assign sh_load = 16'(idx) * (16'(BYTE_SIZE) << code_r);
  always_comb begin
    found = 1'b0;
    fidx = '0;
    for (int i = VECTOR_SIZE - 1; i >= 0; i--)
      if (mask_r[i] && IW'(i) < len_r && IW'(i) >= idx) begin
        found = 1'b1;
        fidx = IW'(i);
      end
  end
  always_comb begin
    state_n = state == IDLE ? (bus.mem_access_enabled ? (go ? ISSUE : DONE) : IDLE)
            : state == ISSUE ? (!found ? DONE : issue ? WAIT : ISSUE)
            : state == WAIT ? (fin ? ISSUE : WAIT) : IDLE;
    bus.mem_vis_status = state == IDLE ? 2'd0 : state == DONE ? 2'd3
                       : (state == ISSUE && found && !resting) ? 2'd2 : 2'd1;
    bus.cache_vis_signal = issue ? op_r : 2'd0;
    bus.mem_vis_addr = issue ? base_r + ADDR_WIDTH'(fidx) * stride_r : '0;
    bus.data_type = issue ? {1'b0, code_r} : 3'd0;
    bus.cache_written_data = (issue && op_r == 2'd2) ? (LEN'(wvec_r >> sh_issue) & emask) : '0;
    bus.write_length = IW'(1);
    bus.vector_data = vbuf;
    bus.scalar_data = sbuf;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_r <= '0;
      vec_r <= 1'b0;
      code_r <= '0;
      base_r <= '0;
      stride_r <= '0;
      len_r <= '0;
      mask_r <= '0;
      wvec_r <= '0;
      idx <= '0;
      vbuf <= '0;
      sbuf <= '0;
    end else begin
      if (accept) begin
        op_r <= bus.data_vis_signal;
        vec_r <= bus.is_vector;
        code_r <= bus.is_vector ? bus.vector_data_type[1:0] : bus.scalar_data_type;
        base_r <= bus.data_addr;
        stride_r <= bus.is_vector ? bus.stride : '0;
        len_r <= !bus.is_vector ? IW'(1) : bus.length > IW'(VECTOR_SIZE) ? IW'(VECTOR_SIZE) : bus.length;
        mask_r <= bus.is_vector ? bus.mask : VECTOR_SIZE'(1);
        wvec_r <= bus.is_vector ? bus.written_vector_data : VW'(bus.written_scalar_data);
        idx <= '0;
        // load results stay visible until the next load replaces them
        if (bus.data_vis_signal == 2'd1) begin
          vbuf <= '0;
          sbuf <= '0;
        end
      end
      if (issue) idx <= fidx;
      if (state == WAIT && fin) begin
        idx <= idx + IW'(1);
        if (op_r == 2'd1 && vec_r) vbuf <= vbuf | (VW'(bus.mem_data & emask) << sh_load);
        if (op_r == 2'd1 && !vec_r) sbuf <= bus.mem_data;
      end
    end
endmodule

// File: tb/tb_strided_vector_mem_ctr.sv
// tb_strided_vector_mem_ctr: randomized self-checking bench with a one-cycle cache model and an element-list reference model
module tb_strided_vector_mem_ctr;
  localparam int AW = 17;
  localparam int VW = 256;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  strided_vector_mem_ctr_if bus();
  strided_vector_mem_ctr dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_bad = 0;
  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic fixed_en = 1'b0;
  logic [31:0] fixed_val = 32'h0;
  function automatic logic [31:0] mem_fn(input logic [AW-1:0] a);
    return fixed_en ? fixed_val : (32'(a) * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction
  logic [1:0] r_op[1024];
  logic [AW-1:0] r_addr[1024];
  logic [2:0] r_dt[1024];
  logic [31:0] r_wd[1024];
  int r_n = 0;
  int stall_n = 0;
  int stall_left = 0;
  bit stall_go = 1'b0;
  bit stall_seen = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.d_cache_status <= 2'd0;
      bus.mem_data <= 32'h0;
    end else if (stall_go != stall_seen) begin
      stall_seen <= stall_go;
      stall_left <= stall_n - 1;
      bus.d_cache_status <= 2'd1;
    end else if (stall_left > 0) begin
      stall_left <= stall_left - 1;
      bus.d_cache_status <= 2'd1;
    end else if (bus.cache_vis_signal != 2'd0) begin
      r_op[r_n % 1024] <= bus.cache_vis_signal;
      r_addr[r_n % 1024] <= bus.mem_vis_addr;
      r_dt[r_n % 1024] <= bus.data_type;
      r_wd[r_n % 1024] <= bus.cache_written_data;
      r_n <= r_n + 1;
      bus.d_cache_status <= 2'd2;
      bus.mem_data <= mem_fn(bus.mem_vis_addr);
    end else bus.d_cache_status <= 2'd0;
  end
  task automatic scramble();
    bus.mem_access_enabled = 1'b0;
    bus.data_vis_signal = 2'($urandom);
    bus.is_vector = 1'($urandom);
    bus.scalar_data_type = 2'($urandom);
    bus.vector_data_type = 3'($urandom);
    bus.data_addr = AW'($urandom);
    bus.stride = AW'($urandom);
    bus.length = 4'($urandom);
    bus.mask = 8'($urandom);
    bus.written_scalar_data = $urandom;
    for (int i = 0; i < 8; i++) bus.written_vector_data[i*32 +: 32] = $urandom;
  endtask
  task automatic run(output int lat, output int stalls);
    @(posedge clk);
    #1 scramble();
    lat = 0;
    stalls = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_vis_status == 2'd2) stalls++;
    end while (bus.mem_vis_status != 2'd3 && lat < 300);
  endtask
  task automatic do_test(input string tag, input logic [1:0] op, input logic vec, input logic [1:0] sdt,
                         input logic [2:0] vdt, input logic [AW-1:0] a, input logic [AW-1:0] s,
                         input logic [3:0] len, input logic [7:0] m, input logic [31:0] ws,
                         input logic [VW-1:0] wv, input int stall, input bit early);
    int k, ew, n, lat, st, base;
    logic [AW-1:0] ea[8];
    logic [31:0] ewd[8];
    logic [31:0] word, e;
    logic [VW-1:0] evec;
    logic [31:0] escl;
    logic [7:0] mm;
    logic [AW-1:0] cur;
    logic [2:0] edt;
    k = 0;
    evec = '0;
    escl = '0;
    ew = vec ? (1 << vdt[1:0]) : (1 << sdt);
    n = vec ? (len > 4'd8 ? 8 : int'(len)) : 1;
    mm = vec ? m : 8'd1;
    edt = {1'b0, vec ? vdt[1:0] : sdt};
    cur = a;
    if (op == 2'd1 || op == 2'd2)
      for (int i = 0; i < n; i++) begin
        if (mm[i]) begin
          ea[k] = cur;
          word = mem_fn(cur);
          e = '0;
          for (int b = 0; b < ew; b++) begin
            if (vec) evec[(i*ew+b)*8 +: 8] = word[b*8 +: 8];
            e[b*8 +: 8] = vec ? wv[(i*ew+b)*8 +: 8] : ws[b*8 +: 8];
          end
          if (!vec) escl = word;
          ewd[k] = e;
          k++;
        end
        cur = cur + (vec ? s : AW'(0));
      end
    if (early) begin
      bus.mem_access_enabled = 1'b1;
      bus.data_vis_signal = op; bus.is_vector = vec; bus.scalar_data_type = sdt; bus.vector_data_type = vdt;
      bus.data_addr = a; bus.stride = s; bus.length = len; bus.mask = m;
      bus.written_scalar_data = ws; bus.written_vector_data = wv;
      @(negedge clk);
      check({tag, " done-cycle request ignored"}, VW'(bus.mem_vis_status), VW'(0));
    end else begin
      @(negedge clk);
      bus.mem_access_enabled = 1'b1;
      bus.data_vis_signal = op; bus.is_vector = vec; bus.scalar_data_type = sdt; bus.vector_data_type = vdt;
      bus.data_addr = a; bus.stride = s; bus.length = len; bus.mask = m;
      bus.written_scalar_data = ws; bus.written_vector_data = wv;
    end
    base = r_n;
    if (stall > 0) begin
      stall_n = stall;
      stall_go = ~stall_go;
    end
    run(lat, st);
    check({tag, " latency"}, VW'(lat), VW'((op == 2'd1 || op == 2'd2) ? 2*k + 2 + (k > 0 ? stall : 0) : 1));
    check({tag, " stalls"}, VW'(st), VW'(k > 0 ? stall : 0));
    check({tag, " access count"}, VW'(r_n - base), VW'(k));
    for (int j = 0; j < k; j++) begin
      check({tag, " op"}, VW'(r_op[(base+j) % 1024]), VW'(op));
      check({tag, " addr"}, VW'(r_addr[(base+j) % 1024]), VW'(ea[j]));
      check({tag, " data_type"}, VW'(r_dt[(base+j) % 1024]), VW'(edt));
      if (op == 2'd2) check({tag, " store data"}, VW'(r_wd[(base+j) % 1024]), VW'(ewd[j]));
    end
    if (op == 2'd1 && vec) check({tag, " vector_data"}, bus.vector_data, evec);
    if (op == 2'd1 && !vec) check({tag, " scalar_data"}, VW'(bus.scalar_data), VW'(escl));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [VW-1:0] wv;
    logic [1:0] op;
    logic [AW-1:0] s;
    int t;
    rst = 1'b1;
    scramble();
    repeat (2) @(negedge clk);
    check("reset status", VW'(bus.mem_vis_status), VW'(0));
    check("reset cache_vis", VW'(bus.cache_vis_signal), VW'(0));
    check("reset write_length", VW'(bus.write_length), VW'(1));
    check("reset vector_data", bus.vector_data, VW'(0));
    check("reset scalar_data", VW'(bus.scalar_data), VW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle status", VW'(bus.mem_vis_status), VW'(0));
    fixed_en = 1'b1;
    fixed_val = 32'hDEADBEEF;
    do_test("scalar load", 2'd1, 1'b0, 2'd2, 3'd0, 17'h40, 17'h0, 4'd0, 8'h0, 32'h0, '0, 0, 1'b0);
    fixed_en = 1'b0;
    for (int i = 0; i < 8; i++) wv[i*32 +: 32] = $urandom;
    do_test("vec load ew4", 2'd1, 1'b1, 2'd0, 3'd2, 17'h100, 17'd8, 4'd4, 8'b1111, 32'h0, wv, 0, 1'b0);
    do_test("vec store neg", 2'd2, 1'b1, 2'd0, 3'd1, 17'h4, 17'h1FFFE, 4'd8, 8'b10100101, 32'h0, wv, 0, 1'b0);
    do_test("mask zero", 2'd1, 1'b1, 2'd0, 3'd2, 17'h200, 17'd4, 4'd8, 8'h00, 32'h0, wv, 0, 1'b0);
    do_test("length zero", 2'd1, 1'b1, 2'd0, 3'd0, 17'h200, 17'd4, 4'd0, 8'hFF, 32'h0, wv, 0, 1'b0);
    do_test("stall", 2'd1, 1'b1, 2'd0, 3'd1, 17'h300, 17'd6, 4'd2, 8'h03, 32'h0, wv, 3, 1'b0);
    do_test("early req", 2'd2, 1'b1, 2'd0, 3'd0, 17'h1FFFF, 17'd1, 4'd3, 8'h05, 32'h0, wv, 0, 1'b1);
    do_test("nop", 2'd0, 1'b1, 2'd0, 3'd2, 17'h10, 17'd4, 4'd8, 8'hFF, 32'h0, wv, 0, 1'b0);
    @(negedge clk);
    bus.mem_access_enabled = 1'b1;
    bus.data_vis_signal = 2'd1; bus.is_vector = 1'b1; bus.vector_data_type = 3'd2;
    bus.data_addr = 17'h500; bus.stride = 17'd4; bus.length = 4'd4; bus.mask = 8'hFF;
    @(posedge clk);
    #1 scramble();
    t = 0;
    while (bus.cache_vis_signal == 2'd0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst issue seen", VW'(bus.cache_vis_signal != 2'd0), VW'(1));
    @(negedge clk);
    check("rst pre status", VW'(bus.mem_vis_status), VW'(1));
    rst = 1'b1;
    #1;
    check("rst cache_vis", VW'(bus.cache_vis_signal), VW'(0));
    check("rst status", VW'(bus.mem_vis_status), VW'(0));
    @(negedge clk);
    rst = 1'b0;
    do_test("after rst", 2'd1, 1'b1, 2'd0, 3'd0, 17'h20, 17'h1FFFF, 4'd5, 8'h1B, 32'h0, wv, 0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) wv[i*32 +: 32] = $urandom;
      op = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
      s = $urandom_range(0, 1) ? AW'($urandom) : AW'(int'($urandom_range(0, 32)) - 16);
      do_test("random", op, 1'($urandom), 2'($urandom_range(0, 2)),
              {1'($urandom), 2'($urandom_range(0, 2))}, AW'($urandom), s,
              4'($urandom), 8'($urandom), $urandom, wv, 0, 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
